// File: rtl/cc_cond_unit_if.sv
// Execute-stage ALU result/flag bundle between the producer and the condition-code unit.
// Accept rule: an instruction is taken on a rising edge when in_valid=1 and both
// stall=0 and bubble=0; stall freezes all state, and its result appears one cycle later with out_valid=1.
interface cc_cond_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             stall;
  logic             bubble;
  logic             set_cc;
  logic             exc_suppress;
  logic [WIDTH-1:0] alu_res;
  logic             alu_overflow;
  logic             alu_zero;
  logic [3:0]       ifun;
  logic [2:0]       cc_out;
  logic             out_valid;
  logic             cnd;
  logic             bad_ifun;

  modport master (
    output in_valid, stall, bubble, set_cc, exc_suppress,
    output alu_res, alu_overflow, alu_zero, ifun,
    input  cc_out, out_valid, cnd, bad_ifun
  );

  modport slave (
    input  in_valid, stall, bubble, set_cc, exc_suppress,
    input  alu_res, alu_overflow, alu_zero, ifun,
    output cc_out, out_valid, cnd, bad_ifun
  );
endinterface

// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register and jXX/cmovXX condition evaluator.
// cnd is always computed from the flags held before the current edge.
module cc_cond_unit #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] RESET_CC = 3'b100
) (
  input logic           clk,
  input logic           rst_n,
  cc_cond_unit_if.slave bus
);
  logic [2:0] cc_q, cc_d;
  logic       out_valid_q, out_valid_d;
  logic       cnd_q, cnd_d;
  logic       bad_ifun_q, bad_ifun_d;
  logic       zf, lt, cnd_eval, bad_eval;

  // lt = SF^OF is the signed "less than" outcome of the last OPq.
  always_comb begin
    zf       = cc_q[2];
    lt       = cc_q[1] ^ cc_q[0];
    cnd_eval = 1'b0;
    bad_eval = 1'b0;
    case (bus.ifun)
      4'd0:    cnd_eval = 1'b1;
      4'd1:    cnd_eval = lt | zf;
      4'd2:    cnd_eval = lt;
      4'd3:    cnd_eval = zf;
      4'd4:    cnd_eval = ~zf;
      4'd5:    cnd_eval = ~lt;
      4'd6:    cnd_eval = ~lt & ~zf;
      default: bad_eval = 1'b1;
    endcase
  end

  always_comb begin
    cc_d        = cc_q;
    out_valid_d = out_valid_q;
    cnd_d       = cnd_q;
    bad_ifun_d  = bad_ifun_q;
    if (!bus.stall) begin
      if (bus.bubble || !bus.in_valid) begin
        out_valid_d = 1'b0;
        cnd_d       = 1'b0;
        bad_ifun_d  = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        cnd_d       = cnd_eval;
        bad_ifun_d  = bad_eval;
        if (bus.set_cc && !bus.exc_suppress) begin
          cc_d = {bus.alu_zero, bus.alu_res[WIDTH-1], bus.alu_overflow};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_q        <= RESET_CC;
      out_valid_q <= 1'b0;
      cnd_q       <= 1'b0;
      bad_ifun_q  <= 1'b0;
    end else begin
      cc_q        <= cc_d;
      out_valid_q <= out_valid_d;
      cnd_q       <= cnd_d;
      bad_ifun_q  <= bad_ifun_d;
    end
  end

  assign bus.cc_out    = cc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cnd       = cnd_q;
  assign bus.bad_ifun  = bad_ifun_q;
endmodule

// File: tb/tb_cc_cond_unit.sv
// Bench for cc_cond_unit: condition table, directed multi-cycle sequences, random traffic.
// Observed word is {cc_out, out_valid, cnd, bad_ifun}.
module tb_cc_cond_unit;
  localparam int W = 6;

  logic clk;
  logic rst_n;
  cc_cond_unit_if #(.WIDTH(64)) bus ();

  cc_cond_unit #(.WIDTH(64), .RESET_CC(3'b100)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  logic [2:0] cc_m;
  logic       ov_m, cnd_m, bad_m;

  function automatic logic cond_ref(input logic [2:0] cc, input logic [3:0] fn);
    logic z, s, o;
    {z, s, o} = cc;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (s != o) || z;
      4'd2:    return (s != o);
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return (s == o);
      4'd6:    return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cc/ov/cnd/bad=%b expected %b", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input string name, input logic rst, iv, st, bb, sc, ex,
                      input logic [63:0] res, input logic ovf, zero, input logic [3:0] fn);
    logic c;
    rst_n = rst; bus.in_valid = iv; bus.stall = st; bus.bubble = bb;
    bus.set_cc = sc; bus.exc_suppress = ex; bus.alu_res = res;
    bus.alu_overflow = ovf; bus.alu_zero = zero; bus.ifun = fn;
    if (!rst) begin
      cc_m = 3'b100; ov_m = 1'b0; cnd_m = 1'b0; bad_m = 1'b0;
    end else if (st) begin
      // hold
    end else if (bb || !iv) begin
      ov_m = 1'b0; cnd_m = 1'b0; bad_m = 1'b0;
    end else begin
      c = cond_ref(cc_m, fn);
      ov_m = 1'b1; cnd_m = c; bad_m = (fn > 4'd6);
      if (sc && !ex) cc_m = {zero, res[63], ovf};
    end
    exp_q.push_back({cc_m, ov_m, cnd_m, bad_m});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, exp_q.pop_front());
    end
  endtask

  task automatic accept(input string name, input logic sc, ex, input logic [63:0] res,
                        input logic ovf, zero, input logic [3:0] fn);
    step(name, 1'b1, 1'b1, 1'b0, 1'b0, sc, ex, res, ovf, zero, fn);
  endtask

  task automatic do_reset();
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
  endtask

  typedef struct {
    logic [2:0] cc;
    logic [3:0] fn;
    logic       exp_cnd;
    logic       exp_bad;
  } vec_t;

  vec_t vecs[27];

  initial begin
    vecs[0]  = '{3'b100, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{3'b100, 4'd3, 1'b1, 1'b0};
    vecs[2]  = '{3'b100, 4'd4, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 4'd1, 1'b1, 1'b0};
    vecs[4]  = '{3'b100, 4'd2, 1'b0, 1'b0};
    vecs[5]  = '{3'b100, 4'd5, 1'b1, 1'b0};
    vecs[6]  = '{3'b100, 4'd6, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 4'd2, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 4'd6, 1'b1, 1'b0};
    vecs[9]  = '{3'b010, 4'd2, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 4'd1, 1'b1, 1'b0};
    vecs[11] = '{3'b010, 4'd5, 1'b0, 1'b0};
    vecs[12] = '{3'b010, 4'd6, 1'b0, 1'b0};
    vecs[13] = '{3'b001, 4'd2, 1'b1, 1'b0};
    vecs[14] = '{3'b001, 4'd5, 1'b0, 1'b0};
    vecs[15] = '{3'b000, 4'd6, 1'b1, 1'b0};
    vecs[16] = '{3'b000, 4'd5, 1'b1, 1'b0};
    vecs[17] = '{3'b000, 4'd4, 1'b1, 1'b0};
    vecs[18] = '{3'b000, 4'd3, 1'b0, 1'b0};
    vecs[19] = '{3'b000, 4'd1, 1'b0, 1'b0};
    vecs[20] = '{3'b110, 4'd1, 1'b1, 1'b0};
    vecs[21] = '{3'b110, 4'd3, 1'b1, 1'b0};
    vecs[22] = '{3'b110, 4'd6, 1'b0, 1'b0};
    vecs[23] = '{3'b000, 4'd9, 1'b0, 1'b1};
    vecs[24] = '{3'b011, 4'd15, 1'b0, 1'b1};
    vecs[25] = '{3'b100, 4'd7, 1'b0, 1'b1};
    vecs[26] = '{3'b111, 4'd6, 1'b0, 1'b0};

    rst_n = 1'b0; bus.in_valid = 1'b0; bus.stall = 1'b0; bus.bubble = 1'b0;
    bus.set_cc = 1'b0; bus.exc_suppress = 1'b0; bus.alu_res = '0;
    bus.alu_overflow = 1'b0; bus.alu_zero = 1'b0; bus.ifun = 4'd0;
    @(negedge clk);

    // reset state
    do_reset();
    check("reset_const", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, 6'b100_000);

    // set_cc with negative overflowing result, then conditions on the new flags
    accept("setcc_neg", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 4'd0);
    check("setcc_neg_cc", {3'b0, bus.cc_out}, 6'b000_011);
    accept("l_after_set", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd2);
    check("l_after_set_cnd", {5'b0, bus.cnd}, 6'd0);
    accept("g_after_set", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd6);
    check("g_after_set_cnd", {5'b0, bus.cnd}, 6'd1);

    // reset flags: e / ne / invalid ifun
    do_reset();
    accept("e_reset", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd3);
    accept("ne_reset", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd4);
    accept("bad_ifun9", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd9);
    check("bad_ifun9_const", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, 6'b100_101);

    // exception suppression blocks the CC write but still yields a result
    accept("exc_suppress", 1'b1, 1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 4'd0);
    check("exc_suppress_const", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, 6'b100_110);

    // stall three cycles with changing inputs, then bubble, then stall+bubble
    accept("pre_stall", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd3);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {$urandom, $urandom},
           1'b1, 1'b0, 4'($urandom_range(0, 15)));
    check("stall_frozen", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, 6'b100_110);
    step("bubble", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 4'd0);
    check("bubble_const", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, 6'b100_000);
    accept("pre_sb", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    step("stall_bubble", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);

    // set_cc and conditional ifun together: cnd sees old ZF
    accept("setcc_and_e", 1'b1, 1'b0, 64'd5, 1'b0, 1'b0, 4'd3);
    check("setcc_and_e_const", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun}, 6'b000_110);

    // reset during stall wins
    accept("pre_rst_stall", 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 4'd4);
    step("rst_in_stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);

    // condition table: load flags through set_cc, then evaluate
    for (int i = 0; i < 27; i++) begin
      accept("tbl_load", 1'b1, 1'b0, {vecs[i].cc[1], 63'd0}, vecs[i].cc[0], vecs[i].cc[2], 4'd0);
      accept("tbl_eval", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, vecs[i].fn);
      check("tbl_const", {bus.cc_out, bus.out_valid, bus.cnd, bus.bad_ifun},
            {vecs[i].cc, 1'b1, vecs[i].exp_cnd, vecs[i].exp_bad});
    end

    // random back-to-back traffic
    for (int i = 0; i < 60; i++)
      step("random", 1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
